// File: rtl/rs_ff_bank.sv
// rs_ff_bank -- bank of WIDTH edge-triggered RS flip-flops with a shared gate
// enable and a run-time policy for the S=R=1 condition, plus sticky error
// reporting and a saturating count of invalid-input cycles.
//
// Ports
//   CLK      rising-edge clock
//   RST_L    synchronous active-low reset, wins over every other input
//   E        gate enable (1 = update, 0 = hold)
//   S, R     per-bit set / reset, WIDTH bits each
//   MODE     S=R=1 policy: 00 hold, 01 reset, 10 set, 11 toggle
//   CLR_ERR  clears ERR / ERR_CNT (a coincident invalid cycle wins)
//   Q, Q_L   stored state and its complement
//   ERR      sticky invalid-cycle flag
//   ERR_CNT  saturating invalid-cycle counter

// Single flip-flop lane. The bank instantiates one per bit.
module rs_ff_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       e,
  input  logic       s,
  input  logic       r,
  input  logic [1:0] mode,
  output logic       q
);

  logic q_nxt;

  always_comb begin
    q_nxt = q;
    if (e) begin
      unique case ({s, r})
        2'b10:   q_nxt = 1'b1;
        2'b01:   q_nxt = 1'b0;
        2'b11: begin
          unique case (mode)
            2'b00:   q_nxt = q;
            2'b01:   q_nxt = 1'b0;
            2'b10:   q_nxt = 1'b1;
            default: q_nxt = ~q;
          endcase
        end
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) q <= RST_VAL;
    else        q <= q_nxt;
  end

endmodule

module rs_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST_L,
  input  logic             E,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic [1:0]       MODE,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_L,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    rs_ff_bit #(.RST_VAL(RESET_VAL[i])) u_bit (
      .clk  (CLK),
      .rst_l(RST_L),
      .e    (E),
      .s    (S[i]),
      .r    (R[i]),
      .mode (MODE),
      .q    (Q[i])
    );
  end

  // Derived from the Q register only, so the pair can never agree.
  assign Q_L = ~Q;

  // One event per cycle no matter how many bits collide, and independent of
  // MODE: even a well-defined policy still flags the conflicting request.
  logic invalid;
  assign invalid = E & (|(S & R));

  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      ERR     <= 1'b0;
      ERR_CNT <= '0;
    end else if (invalid) begin
      ERR <= 1'b1;
      // A clear in the same cycle is overridden: this event becomes the first.
      if (CLR_ERR)             ERR_CNT <= CNT_W'(1);
      else if (ERR_CNT != '1)  ERR_CNT <= ERR_CNT + CNT_W'(1);
    end else if (CLR_ERR) begin
      ERR     <= 1'b0;
      ERR_CNT <= '0;
    end
  end

endmodule

// File: tb/tb_rs_ff_bank.sv
module tb_rs_ff_bank;

  localparam int         WIDTH = 8;
  localparam int         CNT_W = 3;
  localparam logic [7:0] RV    = 8'hA5;

  logic             clk = 1'b0;
  logic             rst_l = 1'b1;
  logic             e = 1'b0;
  logic [WIDTH-1:0] s = '0;
  logic [WIDTH-1:0] r = '0;
  logic [1:0]       mode = 2'b00;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] q, q_l;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  rs_ff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RESET_VAL(RV)) dut (
    .CLK    (clk),
    .RST_L  (rst_l),
    .E      (e),
    .S      (s),
    .R      (r),
    .MODE   (mode),
    .CLR_ERR(clr_err),
    .Q      (q),
    .Q_L    (q_l),
    .ERR    (err),
    .ERR_CNT(err_cnt)
  );

  // Drive one vector away from the active edge and queue what the edge must
  // produce.
  task automatic apply(input logic rl, input logic en, input logic [7:0] sv,
                       input logic [7:0] rv, input logic [1:0] md,
                       input logic cl, input logic [7:0] eq,
                       input logic ee, input logic [CNT_W-1:0] ec);
    exp_t x;
    @(negedge clk);
    rst_l = rl; e = en; s = sv; r = rv; mode = md; clr_err = cl;
    x.q = eq; x.err = ee; x.cnt = ec;
    exp_q.push_back(x);
  endtask

  // Monitor: every edge that has a queued expectation is checked 1 time unit
  // after the edge.
  always @(posedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      #1;
      checks++;
      if (q !== x.q) begin
        errors++;
        $display("FAIL q: got %h expected %h", q, x.q);
      end
      checks++;
      if (q_l !== ~x.q) begin
        errors++;
        $display("FAIL q_l: got %h expected %h", q_l, ~x.q);
      end
      checks++;
      if (err !== x.err) begin
        errors++;
        $display("FAIL err: got %b expected %b", err, x.err);
      end
      checks++;
      if (err_cnt !== x.cnt) begin
        errors++;
        $display("FAIL err_cnt: got %0d expected %0d", err_cnt, x.cnt);
      end
    end
  end

  initial begin
    // reset with conflicting inputs present
    apply(0, 1, 8'hFF, 8'hFF, 2'b11, 1, 8'hA5, 0, 0);
    // clear the bank, then basic set / reset / hold / gate
    apply(1, 1, 8'h00, 8'hFF, 2'b00, 0, 8'h00, 0, 0);
    apply(1, 1, 8'h0F, 8'h00, 2'b00, 0, 8'h0F, 0, 0);
    apply(1, 1, 8'h00, 8'h03, 2'b00, 0, 8'h0C, 0, 0);
    apply(1, 1, 8'h00, 8'h00, 2'b00, 0, 8'h0C, 0, 0);
    apply(1, 0, 8'hF0, 8'h0C, 2'b00, 0, 8'h0C, 0, 0);
    // MODE sweep, S=R=3C
    apply(1, 1, 8'h3C, 8'h3C, 2'b00, 0, 8'h0C, 1, 1);
    apply(1, 1, 8'h3C, 8'h3C, 2'b01, 0, 8'h00, 1, 2);
    apply(1, 1, 8'h3C, 8'h3C, 2'b10, 0, 8'h3C, 1, 3);
    apply(1, 1, 8'h3C, 8'h3C, 2'b11, 0, 8'h00, 1, 4);
    apply(1, 1, 8'h3C, 8'h3C, 2'b11, 0, 8'h3C, 1, 5);
    // invalid pattern with gate closed: nothing moves
    for (int i = 0; i < 3; i++)
      apply(1, 0, 8'hFF, 8'hFF, 2'b11, 0, 8'h3C, 1, 5);
    // clear alone, then clear colliding with an invalid cycle
    apply(1, 1, 8'h00, 8'h00, 2'b00, 1, 8'h3C, 0, 0);
    apply(1, 1, 8'h01, 8'h01, 2'b00, 1, 8'h3C, 1, 1);
    // clear with gate closed still clears
    apply(1, 0, 8'hFF, 8'hFF, 2'b00, 1, 8'h3C, 0, 0);
    // saturation: 3-bit counter stops at 7
    for (int i = 0; i < 10; i++)
      apply(1, 1, 8'h01, 8'h01, 2'b00, 0, 8'h3C, 1,
            (i < 7) ? CNT_W'(i + 1) : CNT_W'(7));
    // reset mid-run discards the set request
    apply(0, 1, 8'hFF, 8'h00, 2'b00, 0, 8'hA5, 0, 0);
    // first post-reset update
    apply(1, 1, 8'hFF, 8'h00, 2'b00, 0, 8'hFF, 0, 0);
    @(negedge clk);
    e = 1'b0; s = '0; r = '0; clr_err = 1'b0;
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
